iob_cache_be_arbiter: RTL and testbench

IOB_CACHE_BE_ARBITER -- requirements
Module: iob_cache_be_arbiter

---
 rtl/iob_cache_be_arbiter_pkg.sv | 18 +
 rtl/iob_cache_beat_counter.sv | 33 +++
 rtl/iob_cache_be_arbiter.sv | 123 ++++++++++++
 tb/tb_iob_cache_be_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/iob_cache_be_arbiter_pkg.sv
// Shared cache back-end configuration and arbiter state encodings.
`ifndef IOB_CACHE_BE_ADDR_W
`define IOB_CACHE_BE_ADDR_W 24
`endif
`ifndef IOB_CACHE_BE_DATA_W
`define IOB_CACHE_BE_DATA_W 32
`endif

package iob_cache_be_arbiter_pkg;

  // Who currently owns the back-end port; IDLE is the mandatory gap between grants.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BEAT  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/iob_cache_beat_counter.sv
// Counts acknowledged beats of a line fill and flags the final beat.
module iob_cache_beat_counter #(
  parameter int unsigned W = 2
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic clear_i,
  input  logic en_i,
  output logic last_o
);

  // A zero-width counter is not legal, so a single-beat line keeps a dummy bit.
  localparam int unsigned CW = (W > 0) ? W : 1;

  logic [CW-1:0] count_q;

  // Beat count: cleared on burst entry, advanced once per routed ack.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + CW'(1);
    end
  end

  // With a single beat per line every beat is the last one.
  always_comb begin
    last_o = (W == 0) ? 1'b1 : (count_q == {CW{1'b1}});
  end

endmodule

// File: rtl/iob_cache_be_arbiter.sv
// Arbitrates the cache read (line fill) and write channels onto one back-end port.
`ifndef IOB_CACHE_BE_ADDR_W
`define IOB_CACHE_BE_ADDR_W 24
`endif
`ifndef IOB_CACHE_BE_DATA_W
`define IOB_CACHE_BE_DATA_W 32
`endif

module iob_cache_be_arbiter
  import iob_cache_be_arbiter_pkg::*;
#(
  parameter int unsigned BE_ADDR_W  = `IOB_CACHE_BE_ADDR_W,
  parameter int unsigned BE_DATA_W  = `IOB_CACHE_BE_DATA_W,
  parameter int unsigned LINE2BE_W  = 2,
  parameter int unsigned MAX_WR_RUN = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   rd_valid_i,
  input  logic [BE_ADDR_W-1:0]   rd_addr_i,
  output logic                   rd_ack_o,
  output logic [BE_DATA_W-1:0]   rd_rdata_o,
  input  logic                   wr_valid_i,
  input  logic [BE_ADDR_W-1:0]   wr_addr_i,
  input  logic [BE_DATA_W-1:0]   wr_wdata_i,
  input  logic [BE_DATA_W/8-1:0] wr_wstrb_i,
  output logic                   wr_ack_o,
  output logic                   be_valid_o,
  output logic [BE_ADDR_W-1:0]   be_addr_o,
  output logic [BE_DATA_W-1:0]   be_wdata_o,
  output logic [BE_DATA_W/8-1:0] be_wstrb_o,
  input  logic [BE_DATA_W-1:0]   be_rdata_i,
  input  logic                   be_ack_i,
  output logic                   busy_o
);

  localparam int unsigned WR_RUN_W = $clog2(MAX_WR_RUN + 1);
  localparam logic [WR_RUN_W-1:0] WR_RUN_MAX = WR_RUN_W'(MAX_WR_RUN);

  arb_state_t          state_q, state_d;
  logic [WR_RUN_W-1:0] wr_run_q, wr_run_d;
  logic                cnt_clear, cnt_en, cnt_last;

  assign rd_rdata_o = be_rdata_i;

  iob_cache_beat_counter #(
    .W (LINE2BE_W)
  ) u_beat_counter (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (cnt_clear),
    .en_i      (cnt_en),
    .last_o    (cnt_last)
  );

  // Arbiter state and the write-run fairness counter.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q  <= IDLE;
      wr_run_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_run_q <= wr_run_d;
    end
  end

  // Grant decision and routing of the owner's request/ack to the back end.
  always_comb begin
    state_d    = state_q;
    wr_run_d   = wr_run_q;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;
    rd_ack_o   = 1'b0;
    wr_ack_o   = 1'b0;
    be_valid_o = 1'b0;
    be_addr_o  = '0;
    be_wdata_o = '0;
    be_wstrb_o = '0;
    busy_o     = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (!rd_valid_i) begin
          wr_run_d = '0;
        end
        if (wr_valid_i && (wr_run_q < WR_RUN_MAX)) begin
          state_d = WR_BEAT;
          if (rd_valid_i && (wr_run_q != WR_RUN_MAX)) begin
            wr_run_d = wr_run_q + WR_RUN_W'(1);
          end
        end else if (rd_valid_i) begin
          state_d   = RD_BURST;
          wr_run_d  = '0;
          cnt_clear = 1'b1;
        end
      end
      RD_BURST: begin
        be_valid_o = rd_valid_i;
        be_addr_o  = rd_addr_i;
        if (rd_valid_i && be_ack_i) begin
          rd_ack_o = 1'b1;
          cnt_en   = 1'b1;
          if (cnt_last) begin
            state_d = IDLE;
          end
        end
      end
      WR_BEAT: begin
        be_valid_o = wr_valid_i;
        be_addr_o  = wr_addr_i;
        be_wdata_o = wr_wdata_i;
        be_wstrb_o = wr_wstrb_i;
        if (wr_valid_i && be_ack_i) begin
          wr_ack_o = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_iob_cache_be_arbiter.sv
// Directed, table-driven bench for the cache back-end arbiter.
module tb_iob_cache_be_arbiter;

  localparam int AW = 24;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam logic [AW-1:0] RD_ADDR = 24'h000100;
  localparam logic [AW-1:0] WR_ADDR = 24'h000040;
  localparam logic [DW-1:0] WDATA   = 32'hA5A5_1234;
  localparam logic [DW-1:0] RDATA   = 32'hDEAD_BEEF;
  localparam logic [SW-1:0] WSTRB   = 4'hF;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          rd_valid, wr_valid, be_ack;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] wr_wdata, be_rdata;
  logic [SW-1:0] wr_wstrb;
  logic          rd_ack, wr_ack, be_valid, busy;
  logic [DW-1:0] rd_rdata, be_wdata;
  logic [AW-1:0] be_addr;
  logic [SW-1:0] be_wstrb;

  logic          z_rd_valid, z_be_ack;
  logic          z_rd_ack, z_wr_ack, z_be_valid, z_busy;
  logic [DW-1:0] z_rd_rdata, z_be_wdata;
  logic [AW-1:0] z_be_addr;
  logic [SW-1:0] z_be_wstrb;

  int checkCount = 0;
  int passCount  = 0;

  typedef struct {
    logic       rst_n;
    logic       rd;
    logic       wr;
    logic       ack;
    logic       busy;
    logic       bev;
    logic       rdack;
    logic       wrack;
    logic [1:0] owner;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  iob_cache_be_arbiter #(
    .BE_ADDR_W (AW), .BE_DATA_W (DW), .LINE2BE_W (2), .MAX_WR_RUN (4)
  ) dut (
    .clk_i (clk), .reset_n_i (reset_n),
    .rd_valid_i (rd_valid), .rd_addr_i (rd_addr), .rd_ack_o (rd_ack), .rd_rdata_o (rd_rdata),
    .wr_valid_i (wr_valid), .wr_addr_i (wr_addr), .wr_wdata_i (wr_wdata), .wr_wstrb_i (wr_wstrb),
    .wr_ack_o (wr_ack),
    .be_valid_o (be_valid), .be_addr_o (be_addr), .be_wdata_o (be_wdata), .be_wstrb_o (be_wstrb),
    .be_rdata_i (be_rdata), .be_ack_i (be_ack), .busy_o (busy)
  );

  iob_cache_be_arbiter #(
    .BE_ADDR_W (AW), .BE_DATA_W (DW), .LINE2BE_W (0), .MAX_WR_RUN (4)
  ) dut0 (
    .clk_i (clk), .reset_n_i (reset_n),
    .rd_valid_i (z_rd_valid), .rd_addr_i (rd_addr), .rd_ack_o (z_rd_ack), .rd_rdata_o (z_rd_rdata),
    .wr_valid_i (1'b0), .wr_addr_i (wr_addr), .wr_wdata_i (wr_wdata), .wr_wstrb_i (wr_wstrb),
    .wr_ack_o (z_wr_ack),
    .be_valid_o (z_be_valid), .be_addr_o (z_be_addr), .be_wdata_o (z_be_wdata), .be_wstrb_o (z_be_wstrb),
    .be_rdata_i (be_rdata), .be_ack_i (z_be_ack), .busy_o (z_busy)
  );

  function automatic vec_t mk(input logic rst_n, input logic rd, input logic wr, input logic ack,
                              input logic ebusy, input logic ebev, input logic erdack,
                              input logic ewrack, input logic [1:0] owner);
    vec_t v;
    v.rst_n = rst_n; v.rd = rd; v.wr = wr; v.ack = ack;
    v.busy = ebusy; v.bev = ebev; v.rdack = erdack; v.wrack = ewrack; v.owner = owner;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic applyStimulus(input vec_t v);
    reset_n  = v.rst_n;
    rd_valid = v.rd;
    wr_valid = v.wr;
    be_ack   = v.ack;
  endtask

  // One cycle: drive, sample mid-cycle against the record, then advance past the edge.
  task automatic runVec(input vec_t v, input string tag);
    logic [AW-1:0] eaddr;
    logic [DW-1:0] ewdata;
    logic [SW-1:0] ewstrb;
    applyStimulus(v);
    eaddr  = (v.owner == 2'd1) ? RD_ADDR : (v.owner == 2'd2) ? WR_ADDR : '0;
    ewdata = (v.owner == 2'd2) ? WDATA : '0;
    ewstrb = (v.owner == 2'd2) ? WSTRB : '0;
    @(negedge clk);
    checkOutput({tag, " busy"},     32'(busy),     32'(v.busy));
    checkOutput({tag, " be_valid"}, 32'(be_valid), 32'(v.bev));
    checkOutput({tag, " rd_ack"},   32'(rd_ack),   32'(v.rdack));
    checkOutput({tag, " wr_ack"},   32'(wr_ack),   32'(v.wrack));
    checkOutput({tag, " be_addr"},  32'(be_addr),  32'(eaddr));
    checkOutput({tag, " be_wdata"}, be_wdata,      ewdata);
    checkOutput({tag, " be_wstrb"}, 32'(be_wstrb), 32'(ewstrb));
    checkOutput({tag, " rd_rdata"}, rd_rdata,      RDATA);
    @(posedge clk);
    #1;
  endtask

  // Single-beat-line instance: drive its own request/ack and check its handshake.
  task automatic zCycle(input logic rd, input logic ack, input logic ebusy, input logic ebev,
                        input logic erdack, input string tag);
    z_rd_valid = rd;
    z_be_ack   = ack;
    @(negedge clk);
    checkOutput({tag, " busy"},     32'(z_busy),     32'(ebusy));
    checkOutput({tag, " be_valid"}, 32'(z_be_valid), 32'(ebev));
    checkOutput({tag, " rd_ack"},   32'(z_rd_ack),   32'(erdack));
    checkOutput({tag, " wr_ack"},   32'(z_wr_ack),   32'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rd_addr = RD_ADDR; wr_addr = WR_ADDR; wr_wdata = WDATA; wr_wstrb = WSTRB; be_rdata = RDATA;
    z_rd_valid = 1'b0; z_be_ack = 1'b0;
    applyStimulus(mk(0,0,0,0, 0,0,0,0,0));
    @(posedge clk);
    #1;

    // Reset state, then a lone write, a lone burst, a write run against a pending read.
    vecs.push_back(mk(0,0,0,0, 0,0,0,0,0));
    vecs.push_back(mk(1,0,1,0, 0,0,0,0,0));
    vecs.push_back(mk(1,0,1,0, 1,1,0,0,2));
    vecs.push_back(mk(1,0,1,1, 1,1,0,1,2));
    vecs.push_back(mk(1,0,0,0, 0,0,0,0,0));
    vecs.push_back(mk(1,0,0,1, 0,0,0,0,0));
    vecs.push_back(mk(1,1,0,0, 0,0,0,0,0));
    vecs.push_back(mk(1,1,0,0, 1,1,0,0,1));
    vecs.push_back(mk(1,1,0,1, 1,1,1,0,1));
    vecs.push_back(mk(1,1,0,0, 1,1,0,0,1));
    vecs.push_back(mk(1,1,0,1, 1,1,1,0,1));
    vecs.push_back(mk(1,1,0,1, 1,1,1,0,1));
    vecs.push_back(mk(1,1,0,0, 1,1,0,0,1));
    vecs.push_back(mk(1,1,0,1, 1,1,1,0,1));
    vecs.push_back(mk(1,0,0,0, 0,0,0,0,0));
    for (int i = 0; i < 4; i++) begin
      vecs.push_back(mk(1,1,1,0, 0,0,0,0,0));
      vecs.push_back(mk(1,1,1,1, 1,1,0,1,2));
    end
    vecs.push_back(mk(1,1,1,0, 0,0,0,0,0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(1,1,1,1, 1,1,1,0,1));
    vecs.push_back(mk(1,1,1,0, 0,0,0,0,0));
    vecs.push_back(mk(1,1,1,1, 1,1,0,1,2));
    vecs.push_back(mk(1,0,0,0, 0,0,0,0,0));
    foreach (vecs[i]) runVec(vecs[i], $sformatf("vec%0d", i));

    // Write arrives during beat 2: burst completes, write follows after one idle cycle.
    runVec(mk(1,1,0,0, 0,0,0,0,0), "late_wr c0");
    runVec(mk(1,1,0,1, 1,1,1,0,1), "late_wr c1");
    runVec(mk(1,1,0,1, 1,1,1,0,1), "late_wr c2");
    runVec(mk(1,1,1,0, 1,1,0,0,1), "late_wr c3");
    runVec(mk(1,1,1,1, 1,1,1,0,1), "late_wr c4");
    runVec(mk(1,1,1,1, 1,1,1,0,1), "late_wr c5");
    runVec(mk(1,0,1,0, 0,0,0,0,0), "late_wr c6");
    runVec(mk(1,0,1,1, 1,1,0,1,2), "late_wr c7");
    runVec(mk(1,0,0,0, 0,0,0,0,0), "late_wr c8");

    // Reset at beat 1 aborts the burst; a fresh burst then needs all four beats.
    runVec(mk(1,1,0,0, 0,0,0,0,0), "rst_burst a0");
    runVec(mk(1,1,0,1, 1,1,1,0,1), "rst_burst a1");
    runVec(mk(0,1,0,0, 1,1,0,0,1), "rst_burst a2");
    runVec(mk(1,0,0,0, 0,0,0,0,0), "rst_burst a3");
    runVec(mk(1,1,0,0, 0,0,0,0,0), "rst_burst b0");
    for (int i = 0; i < 3; i++) runVec(mk(1,1,0,1, 1,1,1,0,1), $sformatf("rst_burst b%0d", i + 1));
    runVec(mk(1,1,0,1, 1,1,1,0,1), "rst_burst b4");
    runVec(mk(1,0,0,0, 0,0,0,0,0), "rst_burst b5");

    // Saturated write run is cleared by reset, so the write wins again afterwards.
    for (int i = 0; i < 4; i++) begin
      runVec(mk(1,1,1,0, 0,0,0,0,0), $sformatf("rst_run w%0d idle", i));
      runVec(mk(1,1,1,1, 1,1,0,1,2), $sformatf("rst_run w%0d beat", i));
    end
    runVec(mk(0,1,1,0, 0,0,0,0,0), "rst_run w9");
    runVec(mk(1,1,1,0, 0,0,0,0,0), "rst_run w10");
    runVec(mk(1,1,1,1, 1,1,0,1,2), "rst_run w11");
    runVec(mk(1,0,0,0, 0,0,0,0,0), "rst_run w12");

    // Single-beat line: one ack ends the burst; stray acks in IDLE are dropped.
    zCycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "l0 c0");
    zCycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "l0 c1");
    zCycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "l0 c2");
    zCycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "l0 c3");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
